// File: rtl/char_render_ctrl.sv
// char_render_ctrl
//   Pixel pipeline controller for the 80x30 text console. It maps each VGA
//   pixel coordinate to a text-buffer address, fetches the ASCII code from a
//   synchronous-read buffer, and drives CharLUT with the glyph row and column.
//   It registers the final pixel with an optional blinking underline cursor,
//   and delays the sync and active strobes so that they line up with the pixel.
//
// Ports
//   clk, rst            : pixel clock and asynchronous active-high reset
//   hcount, vcount      : pixel coordinate from the timing generator
//   in_active           : visible-area flag
//   in_hsync, in_vsync  : active-low syncs
//   buf_raddr/buf_rdata : text-buffer read port (data follows one edge later)
//   lut_char/vidx/hidx  : CharLUT request
//   lut_lit             : CharLUT result (combinational)
//   cursor_en/col/row   : cursor control, sampled at stage 1
//   pix_on, out_*       : pixel and delayed strobes, 3 edges after input
module char_render_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        in_active,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [11:0] buf_raddr,
    input  logic [7:0]  buf_rdata,
    output logic [7:0]  lut_char,
    output logic [3:0]  lut_vidx,
    output logic [2:0]  lut_hidx,
    input  logic        lut_lit,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic        pix_on,
    output logic        out_active,
    output logic        out_hsync,
    output logic        out_vsync
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic        v0;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] addr;
    logic        cur0;
    logic        frame_start;

    // Stage 1
    logic [11:0] raddr_q, raddr_d;
    logic [3:0]  vidx1_q, vidx1_d;
    logic [2:0]  hidx1_q, hidx1_d;
    logic        v1_q, v1_d, cur1_q, cur1_d;
    logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    // Stage 2
    logic [3:0]  vidx2_q, vidx2_d;
    logic [2:0]  hidx2_q, hidx2_d;
    logic        v2_q, v2_d, cur2_q, cur2_d;
    logic        act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    // Stage 3
    logic        pix_q, pix_d;
    logic        act3_q, act3_d, hs3_q, hs3_d, vs3_q, vs3_d;
    // Blink
    logic        vs_prev_q, vs_prev_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;

    always_comb begin
        v0   = in_active && (hcount < 10'd640) && (vcount < 10'd480);
        col  = hcount[9:3];
        row  = vcount[8:4];
        // row*80 as row*64 + row*16, widened so 29*80+79 = 2399 fits
        addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
        // Out-of-range cursor positions are rejected explicitly
        cur0 = cursor_en && (cursor_col < 7'd80) && (cursor_row < 5'd30)
               && (col == cursor_col) && (row == cursor_row);
        frame_start = vs_prev_q && !in_vsync;

        raddr_d = v0 ? addr : raddr_q;
        vidx1_d = vcount[3:0];
        hidx1_d = hcount[2:0];
        v1_d    = v0;
        cur1_d  = cur0;
        act1_d  = in_active;
        hs1_d   = in_hsync;
        vs1_d   = in_vsync;

        vidx2_d = vidx1_q;
        hidx2_d = hidx1_q;
        v2_d    = v1_q;
        cur2_d  = cur1_q;
        act2_d  = act1_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;

        // buf_rdata for this pixel arrives during stage 2, so lut_lit is
        // consumed here in the same cycle
        pix_d  = v2_q && (lut_lit || (cur2_q && blink_q && (vidx2_q >= 4'd14)));
        act3_d = act2_q;
        hs3_d  = hs2_q;
        vs3_d  = vs2_q;

        vs_prev_d   = in_vsync;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = '0;
                blink_d     = !blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q     <= '0;
            vidx1_q     <= '0;
            hidx1_q     <= '0;
            v1_q        <= 1'b0;
            cur1_q      <= 1'b0;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vidx2_q     <= '0;
            hidx2_q     <= '0;
            v2_q        <= 1'b0;
            cur2_q      <= 1'b0;
            act2_q      <= 1'b0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            pix_q       <= 1'b0;
            act3_q      <= 1'b0;
            hs3_q       <= 1'b1;
            vs3_q       <= 1'b1;
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            raddr_q     <= raddr_d;
            vidx1_q     <= vidx1_d;
            hidx1_q     <= hidx1_d;
            v1_q        <= v1_d;
            cur1_q      <= cur1_d;
            act1_q      <= act1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            vidx2_q     <= vidx2_d;
            hidx2_q     <= hidx2_d;
            v2_q        <= v2_d;
            cur2_q      <= cur2_d;
            act2_q      <= act2_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            pix_q       <= pix_d;
            act3_q      <= act3_d;
            hs3_q       <= hs3_d;
            vs3_q       <= vs3_d;
            vs_prev_q   <= vs_prev_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign buf_raddr  = raddr_q;
    assign lut_char   = buf_rdata;
    assign lut_vidx   = vidx2_q;
    assign lut_hidx   = hidx2_q;
    assign pix_on     = pix_q;
    assign out_active = act3_q;
    assign out_hsync  = hs3_q;
    assign out_vsync  = vs3_q;

endmodule
